// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port arbiter: merges load and ALU results onto one write port,
// buffers colliding ALU results in a 2-entry queue and keeps a per-register busy scoreboard.
module rf_writeback_ctrl #(
    parameter int XLEN   = 64,
    parameter int QDEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      chk_ra1,
    input  logic [4:0]      chk_ra2,
    output logic            chk_busy1,
    output logic            chk_busy2,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd,
    output logic            regWrite,
    output logic            sb_err
);
    localparam logic [1:0] QMAX = 2'(QDEPTH);

    logic [31:1]     busy;
    logic [31:0]     busy_v;
    logic [31:0]     busy_nxt;
    logic [4:0]      q_rd   [QDEPTH];
    logic [XLEN-1:0] q_data [QDEPTH];
    logic [1:0]      count;

    logic            alu_acc;
    logic            iss_acc;
    logic            deq;
    logic            enq;
    logic [1:0]      wr_pos;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            err_hit;

    assign busy_v    = {busy, 1'b0};
    assign iss_ready = !rst && !busy_v[iss_rd];
    assign alu_ready = !rst && (count < QMAX);
    assign chk_busy1 = busy_v[chk_ra1];
    assign chk_busy2 = busy_v[chk_ra2];

    always_comb begin
        alu_acc   = alu_valid && alu_ready;
        iss_acc   = iss_valid && iss_ready;
        deq       = !ld_valid && (count != 2'd0);
        enq       = alu_acc && (ld_valid || (count != 2'd0));
        wr_pos    = count - {1'b0, deq};
        sel_valid = 1'b0;
        sel_rd    = 5'd0;
        sel_data  = '0;
        if (ld_valid) begin
            sel_valid = 1'b1;
            sel_rd    = ld_rd;
            sel_data  = ld_data;
        end else if (count != 2'd0) begin
            sel_valid = 1'b1;
            sel_rd    = q_rd[0];
            sel_data  = q_data[0];
        end else if (alu_acc) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end
        // Busy is checked at acceptance, not at writeback, so queued results are judged once.
        err_hit = (ld_valid && (ld_rd != 5'd0) && !busy_v[ld_rd]) ||
                  (alu_acc && (alu_rd != 5'd0) && !busy_v[alu_rd]);
        busy_nxt = busy_v;
        if (regWrite && (wa != 5'd0))
            busy_nxt[wa] = 1'b0;
        if (iss_acc && (iss_rd != 5'd0))
            busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            count    <= 2'd0;
            wa       <= 5'd0;
            wd       <= '0;
            regWrite <= 1'b0;
            sb_err   <= 1'b0;
        end else begin
            busy <= busy_nxt[31:1];
            if (deq) begin
                q_rd[0]   <= q_rd[1];
                q_data[0] <= q_data[1];
            end
            // After a dequeue the old head slot is reused, so the tail position shifts down.
            if (enq) begin
                q_rd[wr_pos[0]]   <= alu_rd;
                q_data[wr_pos[0]] <= alu_data;
            end
            count <= count + {1'b0, enq} - {1'b0, deq};
            if (sel_valid) begin
                wa <= sel_rd;
                wd <= sel_data;
            end
            regWrite <= sel_valid && (sel_rd != 5'd0);
            if (err_hit)
                sb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed test-plan scenarios and random traffic,
// all checked every cycle against a queue/array model of the writeback rules.
module tb_rf_writeback_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  chk_ra1, chk_ra2;
    logic        chk_busy1, chk_busy2;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        regWrite;
    logic        sb_err;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } res_t;

    bit          mbusy [32];
    res_t        mq [$];
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    logic        m_we;
    logic        m_err;

    rf_writeback_ctrl #(.XLEN(64), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .wa(wa), .wd(wd), .regWrite(regWrite), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    // Compare the current cycle against the model, then advance model and DUT by one edge.
    task automatic step();
        logic exp_iss, exp_alu, alu_acc;
        res_t r;
        #1;
        exp_iss = !rst && !mbusy[iss_rd];
        exp_alu = !rst && (mq.size() < 2);
        chk("iss_ready", iss_ready, exp_iss);
        chk("alu_ready", alu_ready, exp_alu);
        chk("chk_busy1", chk_busy1, mbusy[chk_ra1]);
        chk("chk_busy2", chk_busy2, mbusy[chk_ra2]);
        chk("regWrite", regWrite, m_we);
        chk("wa", wa, m_wa);
        chk("wd", wd, m_wd);
        chk("sb_err", sb_err, m_err);
        if (rst) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            mq.delete();
            m_we = 1'b0; m_wa = 5'd0; m_wd = 64'd0; m_err = 1'b0;
        end else begin
            alu_acc = alu_valid && exp_alu;
            if ((ld_valid && ld_rd != 0 && !mbusy[ld_rd]) ||
                (alu_acc && alu_rd != 0 && !mbusy[alu_rd]))
                m_err = 1'b1;
            if (m_we && m_wa != 0) mbusy[m_wa] = 1'b0;
            if (iss_valid && exp_iss && iss_rd != 0) mbusy[iss_rd] = 1'b1;
            if (ld_valid) begin
                if (alu_acc) mq.push_back('{alu_rd, alu_data});
                m_wa = ld_rd; m_wd = ld_data; m_we = (ld_rd != 0);
            end else if (mq.size() > 0) begin
                r = mq.pop_front();
                if (alu_acc) mq.push_back('{alu_rd, alu_data});
                m_wa = r.rd; m_wd = r.d; m_we = (r.rd != 0);
            end else if (alu_acc) begin
                m_wa = alu_rd; m_wd = alu_data; m_we = (alu_rd != 0);
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        iss_valid = 1'b1; iss_rd = rd;
        step();
        iss_valid = 1'b0;
    endtask

    initial begin
        logic [4:0] nxt_alu;
        rst = 1'b1; idle();
        iss_rd = 0; chk_ra1 = 0; chk_ra2 = 0;
        alu_rd = 0; alu_data = 0; ld_rd = 0; ld_data = 0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        m_we = 1'b0; m_wa = 5'd0; m_wd = 64'd0; m_err = 1'b0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        step();

        // bypass
        chk_ra1 = 5;
        issue(5);
        alu_valid = 1'b1; alu_rd = 5; alu_data = 64'h1234;
        step();
        idle();
        chk("byp_we", regWrite, 1'b1);
        chk("byp_wa", wa, 5'd5);
        chk("byp_wd", wd, 64'h1234);
        chk("byp_busy_n1", chk_busy1, 1'b1);
        step();
        chk("byp_busy_n2", chk_busy1, 1'b0);

        // load/ALU collision
        issue(7); issue(8);
        ld_valid = 1'b1; ld_rd = 7; ld_data = 64'hAA;
        alu_valid = 1'b1; alu_rd = 8; alu_data = 64'hBB;
        step();
        idle();
        chk("col_wa0", wa, 5'd7);
        chk("col_ready", alu_ready, 1'b1);
        step();
        chk("col_wa1", wa, 5'd8);
        chk("col_wd1", wd, 64'hBB);
        step();

        // queue full under sustained loads
        issue(9); issue(10); issue(11);
        for (int i = 0; i < 4; i++) issue(5'(20 + i));
        nxt_alu = 9;
        for (int c = 0; c < 4; c++) begin
            ld_valid = 1'b1; ld_rd = 5'(20 + c); ld_data = 64'(c);
            alu_valid = 1'b1; alu_rd = nxt_alu; alu_data = 64'(nxt_alu) << 8;
            if (mq.size() < 2) nxt_alu = nxt_alu + 1;
            step();
            if (c == 1) chk("qf_ready_c3", alu_ready, 1'b0);
        end
        ld_valid = 1'b0;
        step();
        chk("qf_wa9", wa, 5'd9);
        step();
        alu_valid = 1'b0;
        chk("qf_wa10", wa, 5'd10);
        step();
        chk("qf_wa11", wa, 5'd11);
        step();

        // WAW interlock
        issue(3);
        iss_valid = 1'b1; iss_rd = 3;
        alu_valid = 1'b1; alu_rd = 3; alu_data = 64'h33;
        step();
        alu_valid = 1'b0;
        step();
        chk("waw_ready", iss_ready, 1'b1);
        step();
        iss_rd = 0;
        step();
        chk("waw_x0_ready", iss_ready, 1'b1);
        idle();

        // x0 result and error flag
        alu_valid = 1'b1; alu_rd = 0; alu_data = 64'h55;
        step();
        idle();
        chk("x0_we", regWrite, 1'b0);
        chk("x0_err", sb_err, 1'b0);
        ld_valid = 1'b1; ld_rd = 12; ld_data = 64'hC;
        step();
        idle();
        chk("err_set", sb_err, 1'b1);
        step(); step(); step();
        chk("err_sticky", sb_err, 1'b1);

        // reset with queued results
        issue(13); issue(14);
        chk_ra1 = 13; chk_ra2 = 14;
        ld_valid = 1'b1; ld_rd = 13; ld_data = 64'h1;
        alu_valid = 1'b1; alu_rd = 14; alu_data = 64'h2;
        step();
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_we", regWrite, 1'b0);
        chk("rst_wa", wa, 5'd0);
        chk("rst_busy1", chk_busy1, 1'b0);
        chk("rst_busy2", chk_busy2, 1'b0);
        step();
        chk("rst_ready", alu_ready, 1'b1);
        chk("rst_nowrite", regWrite, 1'b0);
        step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_rd    = 5'($urandom);
            ld_valid  = ($urandom_range(0, 2) == 0);
            ld_rd     = 5'($urandom);
            ld_data   = {$urandom, $urandom};
            alu_valid = $urandom_range(0, 1);
            alu_rd    = 5'($urandom);
            alu_data  = {$urandom, $urandom};
            chk_ra1   = 5'($urandom);
            chk_ra2   = 5'($urandom);
            step();
        end
        rst = 1'b0; idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rf_writeback_ctrl.md
# rf_writeback_ctrl

Write-side controller for the 64-bit, 32-entry integer register file in the pipelined core. It merges ALU and load results onto the register file's single write port (`wa`, `wd`, `regWrite`). It buffers ALU results that collide with load writebacks and keeps a per-register busy scoreboard, which issue/decode logic queries for RAW and WAW interlocks. It sits between the EX/MEM result paths and the register file, replacing direct MEM/WB drive of the write port.

## Interface
- `XLEN`, default 64: data width of results and `wd`.
- `QDEPTH`, default 2: ALU result queue depth. This document fixes 2; other values need not be supported.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `iss_valid` in 1: issue stage requests to mark `iss_rd` busy.
- `iss_rd` in 5: destination register of the issuing instruction.
- `iss_ready` out 1: issue accepted this cycle if `iss_valid && iss_ready`.
- `chk_ra1`, `chk_ra2` in 5: source registers to check.
- `chk_busy1`, `chk_busy2` out 1: the corresponding register has a pending write.
- `alu_valid` in 1: ALU result present.
- `alu_rd` in 5: ALU result destination.
- `alu_data` in XLEN: ALU result value.
- `alu_ready` out 1: ALU result accepted if `alu_valid && alu_ready`.
- `ld_valid` in 1: load result present. Always accepted; no backpressure.
- `ld_rd` in 5: load result destination.
- `ld_data` in XLEN: load result value.
- `wa` out 5: register file write address (registered).
- `wd` out XLEN: register file write data (registered).
- `regWrite` out 1: register file write enable (registered).
- `sb_err` out 1: sticky; a result arrived for a non-busy register (rd != 0).

## Operation
- **Scoreboard**
  - `busy[31:1]` is a register array; `busy[0]` is hardwired 0.
  - `iss_ready = !rst && !busy[iss_rd]`. This is the WAW interlock; `iss_rd` = 0 is always ready.
  - Accepted issue with `iss_rd` != 0 sets `busy[iss_rd]` at the edge.
  - An edge with `regWrite && wa != 0` clears `busy[wa]`.
  - A register being cleared can never be set in the same cycle, because `iss_ready` is 0 for it.
  - `chk_busy1/2 = busy[chk_ra1/2]`, combinational from registered state. There is no bypass on the clearing cycle.
- **ALU queue**
  - 2-entry FIFO of {rd, data}, with a 2-bit count.
  - `alu_ready = !rst && (count < 2)`. This is based on the count at the start of the cycle; a same-cycle dequeue does not raise it.
- **Output selection**, in priority order each cycle:
  1. `ld_valid`: load goes to the output stage. An accepted ALU result is enqueued.
  2. Queue non-empty: the head is dequeued to the output stage. An accepted ALU result is enqueued at the tail, so count is unchanged.
  3. Queue empty and ALU accepted: the ALU result goes directly to the output stage (bypass).
  4. Otherwise: the output stage gets `regWrite` = 0.
- **Output stage**
  - `wa <= sel_rd`, `wd <= sel_data`, `regWrite <= sel_valid && sel_rd != 0`.
  - When nothing is selected, `wa` and `wd` hold their previous values.
  - A result with rd = 0 consumes its slot but produces no write.
- **Error flag**
  - `sb_err` is set at an edge where an accepted load or ALU result has rd != 0 and `busy[rd] == 0`.
  - It is cleared only by `rst`.
- **Ordering:** ALU results write back in acceptance order. A load never waits behind queued ALU results.

## Timing
- **Reset (`rst` high at an edge)**
  - `busy` cleared, queue emptied, `regWrite` = 0, `wa` = 0, `wd` = 0, `sb_err` = 0.
  - While `rst` is high, `iss_ready` = 0 and `alu_ready` = 0, and `ld_valid` is ignored.
  - Reset mid-operation drops queued and in-flight results with no write.
- **Load latency:** accepted at edge N, so `regWrite` is high for cycle N+1 and the register file captures at edge N+2. `busy` clears at edge N+2, and `chk_busy` is low from cycle N+2.
- **ALU latency:**
  - Bypass path: same as the load path.
  - Queued path: one extra cycle per load that preempts it.
- **Sustained load traffic:** ALU results stall. After 2 queued results, `alu_ready` drops until a cycle without `ld_valid`.
- **Throughput:** one register file write per cycle maximum.

## Test plan
- **Bypass:** issue rd = 5, then ALU {rd=5, data=0x1234} at edge N -> `regWrite` = 1, `wa` = 5, `wd` = 0x1234 in cycle N+1; `chk_busy`(5) = 1 through N+1 and 0 from N+2.
- **Collision:** load {rd=7, 0xAA} and ALU {rd=8, 0xBB} in the same cycle -> writes to 7 then 8 in consecutive cycles; `alu_ready` stays 1.
- **Queue full:** 4 consecutive cycles of `ld_valid`, with ALU offering rd = 9, 10, 11 -> 9 and 10 accepted, `alu_ready` = 0 from the 3rd cycle; after loads stop, writes occur in order 9, 10, then 11 is accepted.
- **WAW interlock:** issue rd = 3 and hold a second issue of rd = 3 -> `iss_ready` = 0 until the cycle after the rd = 3 write; rd = 0 issues are always ready.
- **x0 and error:** ALU result rd = 0 -> no `regWrite`, `sb_err` stays 0; load rd = 12 with no prior issue -> `sb_err` = 1, and it stays set until `rst`.
- **Reset mid-operation:** 2 queued ALU results, `rst` pulsed for 1 cycle -> no writes follow; all `chk_busy` = 0, `regWrite` = 0, `wa` = 0; `alu_ready` = 1 the cycle after `rst` falls.
